// File: rtl/pipe_stage_skid_pkg.sv
// Shared definitions for the pipeline-stage registers: FSM states, packed
// field offsets used by instantiators and per-stage bubble constants.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int OCC_W = 2;

  // EX/MEM control byte layout
  localparam int EX_MEM_CTRL_W     = 8;
  localparam int CTRL_REGWR_BIT    = 0;
  localparam int CTRL_MEMWR_BIT    = 1;
  localparam int CTRL_MEMRD_BIT    = 2;
  localparam int CTRL_MEMTOREG_LSB = 3;
  localparam int CTRL_MEMTOREG_W   = 2;
  localparam int CTRL_PCSRC_LSB    = 5;
  localparam int CTRL_PCSRC_W      = 3;

  // EX/MEM data vector layout
  localparam int EX_MEM_DATA_W  = 128;
  localparam int ALU_RESULT_LSB = 0;
  localparam int READ_DATA2_LSB = 32;
  localparam int CONBA_LSB      = 64;
  localparam int PC_PLUS4_LSB   = 96;

  localparam logic [31:0] CONBA_RST = 32'h8000_0000;
  localparam logic [EX_MEM_DATA_W-1:0] EX_MEM_DATA_RST = {32'h0, CONBA_RST, 64'h0};

  // Bubbles carry no write/read enables
  localparam logic [7:0] IF_ID_BUB  = 8'h00;
  localparam logic [7:0] ID_EX_BUB  = 8'h00;
  localparam logic [7:0] EX_MEM_BUB = 8'h00;
  localparam logic [7:0] MEM_WB_BUB = 8'h00;

  function automatic logic [OCC_W-1:0] occ_of(input state_e s);
    case (s)
      ST_ONE:  occ_of = 2'd1;
      ST_FULL: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between a pipeline stage and its neighbours; the slave
// modport is the stage itself, the master modport is whoever drives it.
interface pipe_stage_skid_if
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [OCC_W-1:0]  occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  modport slave (
    input  in_valid, in_ctrl, in_data, flush, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy, stall_cnt
  );

  modport master (
    output in_valid, in_ctrl, in_data, flush, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy, stall_cnt
  );
endinterface

// File: rtl/pipe_stage_skid_sat_counter.sv
// Up-counter that sticks at all-ones; sat_o flags the sticky condition.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             sat_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign sat_o = &cnt_q;
  assign cnt_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !sat_o) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline-stage register with a 2-entry skid buffer, flush with
// bubble injection and a saturating stall counter.
//
//   state    | meaning
//   ST_EMPTY | nothing held, outputs show a bubble
//   ST_ONE   | head valid, skid free, in_ready=1
//   ST_FULL  | head and skid valid, in_ready=0
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                CTRL_W   = 8,
  parameter int                DATA_W   = 128,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0,
  parameter logic [CTRL_W-1:0] CTRL_BUB = '0,
  parameter logic [DATA_W-1:0] DATA_RST = '0,
  parameter int                CNT_W    = 16
) (
  input logic              clk,
  input logic              reset,
  pipe_stage_skid_if.slave bus
);
  state_e            state_q, state_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [OCC_W-1:0]  occ_q;
  logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d, skid_ctrl_q;
  logic [DATA_W-1:0] head_data_q, skid_data_q;

  logic acc, pop;
  logic ld_head_in, ld_head_skid, ld_skid;
  logic stall_now, stall_sat;

  assign acc = bus.in_valid & in_ready_q;
  assign pop = out_valid_q & bus.out_ready;

  always_comb begin
    state_d      = state_q;
    ld_head_in   = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d    = ST_ONE;
          ld_head_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (acc && pop) begin
          ld_head_in = 1'b1;
        end else if (acc) begin
          state_d = ST_FULL;
          ld_skid = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d      = ST_ONE;
          ld_head_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush kills both entries and any same-cycle capture
    if (bus.flush) begin
      state_d      = ST_EMPTY;
      ld_head_in   = 1'b0;
      ld_head_skid = 1'b0;
      ld_skid      = 1'b0;
    end
  end

  // Head control is forced to the bubble whenever the head goes invalid
  always_comb begin
    head_ctrl_d = head_ctrl_q;
    if (ld_head_in)               head_ctrl_d = bus.in_ctrl;
    else if (ld_head_skid)        head_ctrl_d = skid_ctrl_q;
    else if (state_d == ST_EMPTY) head_ctrl_d = CTRL_BUB;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= '0;
      head_ctrl_q <= CTRL_RST;
      head_data_q <= DATA_RST;
      skid_ctrl_q <= CTRL_RST;
      skid_data_q <= DATA_RST;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_FULL);
      out_valid_q <= (state_d != ST_EMPTY);
      occ_q       <= occ_of(state_d);
      head_ctrl_q <= head_ctrl_d;
      if (ld_head_in)        head_data_q <= bus.in_data;
      else if (ld_head_skid) head_data_q <= skid_data_q;
      if (ld_skid) begin
        skid_ctrl_q <= bus.in_ctrl;
        skid_data_q <= bus.in_data;
      end
    end
  end

  assign stall_now = out_valid_q & ~bus.out_ready;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc_i (stall_now & ~stall_sat),
    .cnt_o (bus.stall_cnt),
    .sat_o (stall_sat)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ctrl  = head_ctrl_q;
  assign bus.out_data  = head_data_q;
  assign bus.occupancy = occ_q;
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register; successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control vector and a data vector through a valid/ready handshake.
- A 2-entry skid buffer gives full throughput with a registered in_ready.
- Adds synchronous flush with bubble injection, per-field reset values, and a saturating stall counter for the pipeline hazard unit.

Parameters:
- CTRL_W, 8, width of control vector (PCSrc/RegWr/MemWr/MemRd/MemToReg packed by instantiator).
- DATA_W, 128, width of data vector (ALUResult/ReadData2/ConBA/... packed).
- CTRL_RST, 0, control value loaded on reset.
- CTRL_BUB, 0, control value presented for a bubble (flush or empty); must deassert all write/read enables.
- DATA_RST, 0, data value loaded on reset (e.g. ConBA field 32'h80000000 placed by instantiator).
- CNT_W, 16, width of stall counter.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous active-low reset.
- in_valid, input, 1, upstream entry valid.
- in_ready, output, 1, stage can accept; registered.
- in_ctrl, input, CTRL_W, upstream control.
- in_data, input, DATA_W, upstream data.
- flush, input, 1, synchronous kill of all held entries.
- out_valid, output, 1, head entry valid.
- out_ready, input, 1, downstream accepts.
- out_ctrl, output, CTRL_W, head control; CTRL_BUB when out_valid=0.
- out_data, output, DATA_W, head data; undefined-but-stable when out_valid=0.
- occupancy, output, 2, entries held (0..2).
- stall_cnt, output, CNT_W, cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Clocking and reset: clk is the clock. reset is asynchronous, active-low.
- Reset values:
  - out_valid=0, out_ctrl=CTRL_RST, out_data=DATA_RST.
  - skid entry invalid, in_ready=1, occupancy=0, stall_cnt=0.
- First bubble: from the first clock after reset deasserts, an empty stage shows CTRL_BUB.
- Storage: head register (drives outputs) and skid register. States EMPTY(0), ONE(1), FULL(2).
- Handshake events: acc = in_valid & in_ready; pop = out_valid & out_ready.
- EMPTY:
  - acc -> ONE; head loads in_ctrl/in_data.
  - Latency 1 cycle input to output.
- ONE:
  - acc & pop -> ONE; head loads input.
  - acc & !pop -> FULL; skid loads input.
  - !acc & pop -> EMPTY.
  - Otherwise hold.
- FULL:
  - in_ready=0, so acc is impossible.
  - pop -> ONE; head loads skid.
  - Otherwise hold.
- in_ready next = (next state != FULL). An upstream driving in_valid while in_ready=0 is ignored, not an error.
- Ordering: strict FIFO; no entry duplicated or dropped except by flush.
- Flush:
  - Priority over everything.
  - Next state EMPTY, both valids 0, out_ctrl=CTRL_BUB, in_ready=1.
  - A same-cycle acc is discarded.
  - A same-cycle pop still counts as consumed downstream.
- Data handling: data registers load only on entry capture; no clear on pop or flush (power). Control is forced to CTRL_BUB whenever the head is invalid.
- stall_cnt: increments when out_valid & !out_ready; holds at all-ones. Not cleared by flush; only reset clears it.
- Reset mid-operation: immediate return to reset values regardless of state; in-flight entries lost.

Decomposition:
- Shared package pipe_pkg holds:
  - State enum {ST_EMPTY, ST_ONE, ST_FULL}.
  - Localparams for packed field offsets used by the instantiators (EX_MEM_CTRL_W, EX_MEM_DATA_W, CONBA_RST=32'h80000000).
  - A bubble constant per stage.
- One natural sub-module: sat_counter (CNT_W, inc, sat output) for stall_cnt.
- Everything else stays inline.

Test Plan:
- Streaming: out_ready=1, in_valid=1 for 8 cycles with data 1..8 -> out_data 1..8 on consecutive cycles, 1-cycle latency, in_ready stays 1, stall_cnt=0.
- Back-pressure:
  - out_ready=0, push A,B -> occupancy 2, in_ready=0 the cycle after B accepted, stall_cnt counts.
  - Release out_ready -> A then B, no loss or duplication.
- Flush while FULL with in_valid=1 (C offered) -> next cycle out_valid=0, out_ctrl=CTRL_BUB, occupancy 0, in_ready=1; C never appears.
- Simultaneous accept and pop in ONE for 5 cycles -> stays ONE, occupancy 1, order preserved.
- Async reset asserted mid-FULL between clock edges -> outputs go to CTRL_RST/DATA_RST (ConBA field 32'h80000000) without a clock edge, stall_cnt=0.
- CNT_W=3, out_valid held with out_ready=0 for 12 cycles -> stall_cnt reaches 7 and holds.
